udp_tx_sched: RTL and testbench

UDP_TX_SCHED -- requirements
Module: udp_tx_sched

---
 rtl/udp_tx_sched.sv | 202 ++++++++++++++++++++
 tb/tb_udp_tx_sched.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_sched.sv
// -----------------------------------------------------------------------------
// udp_tx_sched
//
// Paces UDP datagram transmission out of a byte FIFO. When enough payload is
// buffered (or a flush asks for the residue), the scheduler commands the UDP
// sender with a one-cycle tx_start plus the datagram length. It then waits for
// the sender's tx_done, or gives up after TIMEOUT cycles. Finally it holds off
// for an inter-frame gap before arming again.
//
// Parameters
//   MAX_LEN      largest payload in bytes per datagram (pkt_len is clamped)
//   TIMEOUT      cycles allowed between tx_start and tx_done
//
// Ports
//   clk_125m     in   1   sole clock
//   reset_n      in   1   asynchronous active-low reset
//   enable       in   1   level; allows new datagrams to be started
//   pkt_len      in   16  configured payload bytes per datagram
//   ifg_cycles   in   8   idle cycles after each datagram (0 behaves as 1)
//   fifo_usage   in   12  payload bytes currently buffered in the sender FIFO
//   flush        in   1   pulse; send residual bytes even if below pkt_len
//   tx_done      in   1   pulse from the sender; datagram finished
//   tx_start     out  1   registered one-cycle start command
//   data_length  out  16  payload length of the datagram in flight
//   busy         out  1   high while sending or in the inter-frame gap
//   pkt_cnt      out  16  completed datagrams, wraps at 16 bits
//   timeout_err  out  1   sticky; a datagram never reported tx_done
// -----------------------------------------------------------------------------
module udp_tx_sched #(
  parameter int MAX_LEN = 1472,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk_125m,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] pkt_len,
  input  logic [7:0]  ifg_cycles,
  input  logic [11:0] fifo_usage,
  input  logic        flush,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [15:0] data_length,
  output logic        busy,
  output logic [15:0] pkt_cnt,
  output logic        timeout_err
);

  // The timeout counter only has to reach TIMEOUT-1.
  localparam int              TO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [15:0]     MAX_LEN_16 = 16'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              flush_pending_reg, flush_pending_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic [7:0]        gap_cnt_reg, gap_cnt_next;
  logic              tx_start_reg, tx_start_next;
  logic [15:0]       data_length_reg, data_length_next;
  logic [15:0]       pkt_cnt_reg, pkt_cnt_next;
  logic              timeout_err_reg, timeout_err_next;

  logic [15:0]       len_eff;
  logic [15:0]       usage_ext;
  logic [7:0]        gap_load;
  logic              flush_consume;

  // ---------------------------------------------------------------------------
  // Effective datagram length: a zero length would never start, so treat it
  // as one byte; anything beyond MAX_LEN would not fit a single datagram.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (pkt_len == 16'd0) begin
      len_eff = 16'd1;
    end else if (pkt_len > MAX_LEN_16) begin
      len_eff = MAX_LEN_16;
    end else begin
      len_eff = pkt_len;
    end
  end

  assign usage_ext = {4'd0, fifo_usage};

  // The gap counter holds "cycles remaining minus one", so that the final gap
  // cycle is the one where it reads zero. ifg_cycles of 0 still yields one cycle.
  assign gap_load = (ifg_cycles == 8'd0) ? 8'd0 : (ifg_cycles - 8'd1);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    to_cnt_next      = to_cnt_reg;
    gap_cnt_next     = gap_cnt_reg;
    tx_start_next    = 1'b0;
    data_length_next = data_length_reg;
    pkt_cnt_next     = pkt_cnt_reg;
    timeout_err_next = timeout_err_reg;
    flush_consume    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = ARM;
        end
      end

      ARM: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (usage_ext >= len_eff) begin
          // A full datagram is buffered. Any pending flush survives so the
          // residue behind this datagram still gets sent later.
          data_length_next = len_eff;
          tx_start_next    = 1'b1;
          to_cnt_next      = '0;
          state_next       = SEND;
        end else if (flush_pending_reg) begin
          // The flush is used up whether or not there was anything to send.
          // An empty FIFO must not leave it armed for later data.
          flush_consume = 1'b1;
          if (fifo_usage != 12'd0) begin
            data_length_next = usage_ext;
            tx_start_next    = 1'b1;
            to_cnt_next      = '0;
            state_next       = SEND;
          end
        end
      end

      SEND: begin
        // tx_done is checked first, so it beats a timeout in the same cycle.
        if (tx_done) begin
          pkt_cnt_next = pkt_cnt_reg + 16'd1;
          gap_cnt_next = gap_load;
          state_next   = GAP;
        end else if (to_cnt_reg == TO_LAST) begin
          timeout_err_next = 1'b1;
          gap_cnt_next     = gap_load;
          state_next       = GAP;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end

      GAP: begin
        if (gap_cnt_reg == 8'd0) begin
          state_next = enable ? ARM : IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A new flush on the same cycle the old one is consumed keeps it pending.
  assign flush_pending_next = (flush_pending_reg & ~flush_consume) | flush;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_125m or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      flush_pending_reg <= 1'b0;
      to_cnt_reg        <= '0;
      gap_cnt_reg       <= 8'd0;
      tx_start_reg      <= 1'b0;
      data_length_reg   <= 16'd0;
      pkt_cnt_reg       <= 16'd0;
      timeout_err_reg   <= 1'b0;
    end else begin
      state_reg         <= state_next;
      flush_pending_reg <= flush_pending_next;
      to_cnt_reg        <= to_cnt_next;
      gap_cnt_reg       <= gap_cnt_next;
      tx_start_reg      <= tx_start_next;
      data_length_reg   <= data_length_next;
      pkt_cnt_reg       <= pkt_cnt_next;
      timeout_err_reg   <= timeout_err_next;
    end
  end

  assign tx_start    = tx_start_reg;
  assign data_length = data_length_reg;
  assign pkt_cnt     = pkt_cnt_reg;
  assign timeout_err = timeout_err_reg;

  // Decoded straight from the state, so it falls the moment reset asserts.
  assign busy = (state_reg == SEND) || (state_reg == GAP);

endmodule

// File: tb/tb_udp_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_udp_tx_sched
//
// Self-checking bench for udp_tx_sched. Directed scenario tasks check the
// behaviour against constants taken from the datagram pacing rules. A
// randomized run is compared cycle by cycle with a behavioural model that
// tracks "armed", "age of the datagram in flight" and "gap cycles left".
// -----------------------------------------------------------------------------
module tb_udp_tx_sched;

  localparam int MAX_LEN = 1472;
  localparam int TIMEOUT = 100;

  logic        clk_125m = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] pkt_len = 16'd0;
  logic [7:0]  ifg_cycles = 8'd0;
  logic [11:0] fifo_usage = 12'd0;
  logic        flush = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_start;
  logic [15:0] data_length;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;

  udp_tx_sched #(
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_125m    (clk_125m),
    .reset_n     (reset_n),
    .enable      (enable),
    .pkt_len     (pkt_len),
    .ifg_cycles  (ifg_cycles),
    .fifo_usage  (fifo_usage),
    .flush       (flush),
    .tx_done     (tx_done),
    .tx_start    (tx_start),
    .data_length (data_length),
    .busy        (busy),
    .pkt_cnt     (pkt_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk_125m = ~clk_125m;

  // One line per commanded datagram.
  always @(negedge clk_125m) begin
    if (reset_n && tx_start === 1'b1)
      $display("[%0t] datagram start: data_length=%0d pkt_cnt=%0d", $time, data_length, pkt_cnt);
  end

  // ---------------------------------------------------------------------------
  // Behavioural reference model (state after the most recent clock edge)
  // ---------------------------------------------------------------------------
  bit m_armed;      // waiting for data with enable high
  int m_send_age;   // cycles since tx_start of the datagram in flight, -1 if none
  int m_gap_left;   // gap cycles still to run, including the current one
  int m_len;
  bit m_start;
  int m_cnt;
  bit m_err;
  bit m_fp;         // a flush request not yet acted on

  function automatic void model_reset();
    m_armed = 0; m_send_age = -1; m_gap_left = 0; m_len = 0;
    m_start = 0; m_cnt = 0; m_err = 0; m_fp = 0;
  endfunction

  function automatic int eff_len(input int l);
    if (l == 0) return 1;
    if (l > MAX_LEN) return MAX_LEN;
    return l;
  endfunction

  function automatic void model_step();
    bit consume;
    int leff;
    int usage;
    int gap;
    consume = 0;
    m_start = 0;
    usage = int'(fifo_usage);
    gap = (ifg_cycles == 8'd0) ? 1 : int'(ifg_cycles);
    if (m_send_age >= 0) begin
      if (tx_done) begin
        m_cnt = (m_cnt + 1) % 65536;
        m_send_age = -1;
        m_gap_left = gap;
      end else if (m_send_age == TIMEOUT - 1) begin
        m_err = 1;
        m_send_age = -1;
        m_gap_left = gap;
      end else begin
        m_send_age++;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
      if (m_gap_left == 0) m_armed = enable;
    end else if (m_armed) begin
      leff = eff_len(int'(pkt_len));
      if (!enable) begin
        m_armed = 0;
      end else if (usage >= leff) begin
        m_len = leff; m_start = 1; m_armed = 0; m_send_age = 0;
      end else if (m_fp) begin
        consume = 1;
        if (usage != 0) begin
          m_len = usage; m_start = 1; m_armed = 0; m_send_age = 0;
        end
      end
    end else if (enable) begin
      m_armed = 1;
    end
    m_fp = (m_fp && !consume) || flush;
  endfunction

  // Advance one clock; inputs are stable from posedge+1, outputs read at posedge+1.
  task automatic tick();
    @(negedge clk_125m);
    model_step();
    @(posedge clk_125m);
    #1;
  endtask

  task automatic do_reset();
    enable = 0; flush = 0; tx_done = 0;
    reset_n = 0;
    model_reset();
    #7;
    @(negedge clk_125m);
    reset_n = 1;
    @(posedge clk_125m);
    #1;
  endtask

  // Stimulus helper: tick until tx_start is seen or the budget runs out.
  task automatic wait_start(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (tx_start === 1'b1) seen = 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    model_reset();
    reset_n = 0;
    #3;
    vectors++;
    if ({tx_start, busy, timeout_err, data_length, pkt_cnt} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got tx_start=%b busy=%b err=%b len=%0d cnt=%0d, want all 0",
               tx_start, busy, timeout_err, data_length, pkt_cnt);
    end
    @(negedge clk_125m);
    reset_n = 1;
    @(posedge clk_125m);
    #1;
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_ramp();
    int starts;
    int start_k;
    int n;
    starts = 0; start_k = -1;
    pkt_len = 16'd23; ifg_cycles = 8'd12; enable = 1;
    for (int k = 0; k <= 23; k++) begin
      fifo_usage = 12'(k);
      tick();
      if (tx_start === 1'b1) begin starts++; start_k = k; end
    end
    fifo_usage = 12'd0;
    vectors++;
    if (starts != 1 || start_k != 23) begin
      miscompares++;
      $display("FAIL ramp_start: got %0d starts at usage %0d, want 1 start at usage 23", starts, start_k);
    end
    vectors++;
    if (data_length !== 16'd23) begin
      miscompares++;
      $display("FAIL ramp_len: got %0d want 23", data_length);
    end
    repeat (80) begin
      tick();
      if (tx_start === 1'b1) starts++;
    end
    tx_done = 1; tick(); tx_done = 0;
    vectors++;
    if (pkt_cnt !== 16'd1 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ramp_done: got cnt=%0d err=%b want cnt=1 err=0", pkt_cnt, timeout_err);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; tick(); end
    vectors++;
    if (n != 12) begin
      miscompares++;
      $display("FAIL ramp_gap: got %0d busy cycles after tx_done want 12", n);
    end
    repeat (5) begin
      tick();
      if (tx_start === 1'b1) starts++;
    end
    vectors++;
    if (starts != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ramp_after: got starts=%0d busy=%b want starts=1 busy=0", starts, busy);
    end
  endtask

  task automatic test_len_clamp();
    bit seen;
    do_reset();
    pkt_len = 16'd0; fifo_usage = 12'd1500; ifg_cycles = 8'd2; enable = 1;
    wait_start(10, seen);
    vectors++;
    if (!seen || data_length !== 16'd1) begin
      miscompares++;
      $display("FAIL clamp_zero: got seen=%b len=%0d want seen=1 len=1", seen, data_length);
    end
    pkt_len = 16'd2000;
    tick();
    vectors++;
    if (data_length !== 16'd1) begin
      miscompares++;
      $display("FAIL clamp_hold: got len=%0d in SEND want 1", data_length);
    end
    tx_done = 1; tick(); tx_done = 0;
    wait_start(20, seen);
    vectors++;
    if (!seen || data_length !== 16'd1472) begin
      miscompares++;
      $display("FAIL clamp_max: got seen=%b len=%0d want seen=1 len=1472", seen, data_length);
    end
    tx_done = 1; tick(); tx_done = 0;
    enable = 0;
  endtask

  task automatic test_flush();
    bit seen;
    int starts;
    do_reset();
    pkt_len = 16'd100; fifo_usage = 12'd37; ifg_cycles = 8'd1; enable = 1;
    starts = 0;
    repeat (6) begin tick(); if (tx_start === 1'b1) starts++; end
    vectors++;
    if (starts != 0) begin
      miscompares++;
      $display("FAIL flush_prewait: got %0d starts want 0", starts);
    end
    flush = 1; tick(); flush = 0;
    wait_start(5, seen);
    vectors++;
    if (!seen || data_length !== 16'd37) begin
      miscompares++;
      $display("FAIL flush_send: got seen=%b len=%0d want seen=1 len=37", seen, data_length);
    end
    fifo_usage = 12'd0;
    tx_done = 1; tick(); tx_done = 0;
    repeat (3) tick();
    flush = 1; tick(); flush = 0;
    starts = 0;
    repeat (4) begin tick(); if (tx_start === 1'b1) starts++; end
    fifo_usage = 12'd37;
    repeat (10) begin tick(); if (tx_start === 1'b1) starts++; end
    vectors++;
    if (starts != 0) begin
      miscompares++;
      $display("FAIL flush_empty: got %0d starts after empty flush want 0", starts);
    end
    enable = 0;
  endtask

  task automatic test_timeout();
    bit seen;
    do_reset();
    pkt_len = 16'd10; fifo_usage = 12'd10; ifg_cycles = 8'd3; enable = 1;
    wait_start(10, seen);
    repeat (TIMEOUT - 1) tick();
    vectors++;
    if (!seen || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got seen=%b err=%b at cycle 99 want seen=1 err=0", seen, timeout_err);
    end
    tick();
    vectors++;
    if (timeout_err !== 1'b1 || pkt_cnt !== 16'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_set: got err=%b cnt=%0d busy=%b at cycle 100 want err=1 cnt=0 busy=1",
               timeout_err, pkt_cnt, busy);
    end
    wait_start(20, seen);
    vectors++;
    if (!seen || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_next: got seen=%b err=%b want next start and sticky err=1", seen, timeout_err);
    end
    do_reset();
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: got err=%b after reset want 0", timeout_err);
    end
    enable = 1;
    wait_start(10, seen);
    repeat (TIMEOUT - 1) tick();
    tx_done = 1; tick(); tx_done = 0;
    repeat (3) tick();
    vectors++;
    if (!seen || timeout_err !== 1'b0 || pkt_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL timeout_race: got seen=%b err=%b cnt=%0d want seen=1 err=0 cnt=1",
               seen, timeout_err, pkt_cnt);
    end
    enable = 0;
  endtask

  task automatic test_back_to_back();
    int last;
    int cyc;
    int exp_gap;
    int done_cnt;
    int g;
    do_reset();
    pkt_len = 16'd8; fifo_usage = 12'd8; ifg_cycles = 8'd0; enable = 1;
    last = -1; cyc = 0; exp_gap = 1; done_cnt = 0;
    while (done_cnt < 200 && cyc < 3000) begin
      if (tx_start === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (cyc - last != 2 + exp_gap) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles between starts want %0d", cyc - last, 2 + exp_gap);
          end
        end
        last = cyc;
        g = $urandom_range(0, 5);
        ifg_cycles = 8'(g);
        exp_gap = (g == 0) ? 1 : g;
        tx_done = 1;
        done_cnt++;
      end
      tick();
      tx_done = 0;
      cyc++;
    end
    vectors++;
    if (done_cnt != 200 || pkt_cnt !== 16'd200) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d datagrams cnt=%0d want 200 and 200", done_cnt, pkt_cnt);
    end
    enable = 0;
  endtask

  task automatic test_reset_mid_send();
    bit seen;
    do_reset();
    pkt_len = 16'd5; fifo_usage = 12'd5; ifg_cycles = 8'd1; enable = 1;
    wait_start(10, seen);
    tx_done = 1; tick(); tx_done = 0;
    wait_start(10, seen);
    repeat (3) tick();
    vectors++;
    if (!seen || busy !== 1'b1 || pkt_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL midreset_pre: got seen=%b busy=%b cnt=%0d want 1 1 1", seen, busy, pkt_cnt);
    end
    #2;
    reset_n = 0;
    #1;
    vectors++;
    if ({tx_start, busy, timeout_err, data_length, pkt_cnt} !== 35'd0) begin
      miscompares++;
      $display("FAIL midreset_async: got tx_start=%b busy=%b err=%b len=%0d cnt=%0d want all 0",
               tx_start, busy, timeout_err, data_length, pkt_cnt);
    end
    model_reset();
    enable = 0;
    @(negedge clk_125m);
    reset_n = 1;
    @(posedge clk_125m);
    #1;
    tx_done = 1; tick(); tx_done = 0;
    tick();
    vectors++;
    if (pkt_cnt !== 16'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_stray: got cnt=%0d busy=%b want cnt=0 busy=0", pkt_cnt, busy);
    end
    enable = 1;
    wait_start(10, seen);
    vectors++;
    if (!seen || pkt_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL midreset_resume: got seen=%b cnt=%0d want seen=1 cnt=0", seen, pkt_cnt);
    end
    tx_done = 1; tick(); tx_done = 0;
    enable = 0;
  endtask

  task automatic test_random();
    int r;
    logic [34:0] exp_v;
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      enable = ($urandom_range(0, 19) != 0);
      r = $urandom_range(0, 9);
      if (r == 0)      pkt_len = 16'd0;
      else if (r == 1) pkt_len = 16'($urandom_range(1473, 3000));
      else             pkt_len = 16'($urandom_range(1, 60));
      if ($urandom_range(0, 9) == 0) fifo_usage = 12'($urandom_range(1400, 4095));
      else                           fifo_usage = 12'($urandom_range(0, 70));
      flush = ($urandom_range(0, 19) == 0);
      tx_done = ($urandom_range(0, 59) == 0);
      ifg_cycles = 8'($urandom_range(0, 4));
      tick();
      exp_v = {m_start, (m_send_age >= 0) || (m_gap_left > 0), m_err, 16'(m_len), 16'(m_cnt)};
      vectors++;
      if ({tx_start, busy, timeout_err, data_length, pkt_cnt} !== exp_v) begin
        miscompares++;
        $display("FAIL random_c%0d: got start=%b busy=%b err=%b len=%0d cnt=%0d want start=%b busy=%b err=%b len=%0d cnt=%0d",
                 c, tx_start, busy, timeout_err, data_length, pkt_cnt,
                 exp_v[34], exp_v[33], exp_v[32], exp_v[31:16], exp_v[15:0]);
      end
    end
    enable = 0; flush = 0; tx_done = 0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_len_clamp();
    test_flush();
    test_timeout();
    test_back_to_back();
    test_reset_mid_send();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
